// File: rtl/player_motion.sv
// Per-frame player position/angle update with map collision query over valid/ready.
// Optional PLAYER_STRAFE_EN adds strafe_left/strafe_right sideways movement.
module player_motion #(
  parameter int POS_W      = 16,
  parameter int ANG_W      = 9,
  parameter int ANG_STEPS  = 360,
  parameter int ROT_STEP   = 90,
  parameter int MOVE_STEP  = 64,
  parameter int CELL_SHIFT = 8,
  parameter logic [POS_W-1:0] X_INIT = 16'd384,
  parameter logic [POS_W-1:0] Y_INIT = 16'd384
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      frame_tick,
  input  logic                      forward,
  input  logic                      backward,
  input  logic                      rotateA,
  input  logic                      rotateD,
`ifdef PLAYER_STRAFE_EN
  input  logic                      strafe_left,
  input  logic                      strafe_right,
`endif
  output logic                      map_req_valid,
  input  logic                      map_req_ready,
  output logic [POS_W-CELL_SHIFT-1:0] map_cell_x,
  output logic [POS_W-CELL_SHIFT-1:0] map_cell_y,
  input  logic                      map_rsp_valid,
  input  logic                      map_wall,
  output logic [POS_W-1:0]          pos_x,
  output logic [POS_W-1:0]          pos_y,
  output logic [ANG_W-1:0]          angle,
  output logic                      update_done,
  output logic                      bump,
  output logic                      tick_overrun
);
  localparam logic [ANG_W:0]   ANG_N = (ANG_W+1)'(ANG_STEPS);
  localparam logic [ANG_W:0]   ROT_N = (ANG_W+1)'(ROT_STEP);
  localparam logic [ANG_W-1:0] A_Q1  = ANG_W'(ANG_STEPS/4);
  localparam logic [ANG_W-1:0] A_Q2  = ANG_W'(ANG_STEPS/2);
  localparam logic [ANG_W-1:0] A_Q3  = ANG_W'(3*ANG_STEPS/4);
  localparam logic [POS_W:0]   STEP  = (POS_W+1)'(MOVE_STEP);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state_q, state_d;

  logic [POS_W-1:0] cand_x, cand_y, cand_x_d, cand_y_d;
  logic [POS_W-1:0] x_inc, x_dec, y_inc, y_dec;
  logic [POS_W:0]   x_up, y_up;
  logic [ANG_W:0]   ang_ext, ang_inc, ang_dec;
  logic [ANG_W-1:0] ang_next;
  logic             rot_en, card, want, do_move, accept;
  logic [1:0]       head, ofs, mdir;

  // Rotation wraps modulo ANG_STEPS; computed one bit wider to avoid overflow.
  assign ang_ext  = {1'b0, angle};
  assign ang_inc  = (ang_ext + ROT_N >= ANG_N) ? ang_ext + ROT_N - ANG_N : ang_ext + ROT_N;
  assign ang_dec  = (ang_ext >= ROT_N) ? ang_ext - ROT_N : ang_ext + ANG_N - ROT_N;
  assign rot_en   = rotateA ^ rotateD;
  assign ang_next = rotateA ? ang_inc[ANG_W-1:0] : ang_dec[ANG_W-1:0];

  // Saturating steps in both directions on each axis.
  assign x_up  = {1'b0, pos_x} + STEP;
  assign y_up  = {1'b0, pos_y} + STEP;
  assign x_inc = x_up[POS_W] ? '1 : x_up[POS_W-1:0];
  assign y_inc = y_up[POS_W] ? '1 : y_up[POS_W-1:0];
  assign x_dec = ({1'b0, pos_x} >= STEP) ? pos_x - STEP[POS_W-1:0] : '0;
  assign y_dec = ({1'b0, pos_y} >= STEP) ? pos_y - STEP[POS_W-1:0] : '0;

  // Direction index: 0 = +x, 1 = -y, 2 = -x, 3 = +y; offsets rotate it in quarter turns.
  always_comb begin
    card = 1'b1;
    head = 2'd0;
    if (angle == '0)        head = 2'd0;
    else if (angle == A_Q1) head = 2'd1;
    else if (angle == A_Q2) head = 2'd2;
    else if (angle == A_Q3) head = 2'd3;
    else                    card = 1'b0;
    want = 1'b0;
    ofs  = 2'd0;
    if (forward ^ backward) begin
      want = card;
      ofs  = backward ? 2'd2 : 2'd0;
    end
`ifdef PLAYER_STRAFE_EN
    else if (strafe_left ^ strafe_right) begin
      want = card;
      ofs  = strafe_left ? 2'd1 : 2'd3;
    end
`endif
    mdir     = head + ofs;
    cand_x_d = pos_x;
    cand_y_d = pos_y;
    case (mdir)
      2'd0:    cand_x_d = x_inc;
      2'd1:    cand_y_d = y_dec;
      2'd2:    cand_x_d = x_dec;
      default: cand_y_d = y_inc;
    endcase
    do_move = want && ((cand_x_d != pos_x) || (cand_y_d != pos_y));
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (frame_tick) begin
        accept = 1'b1;
        if (do_move) state_d = REQ;
      end
      REQ:  if (map_req_ready) state_d = WAIT;
      WAIT: if (map_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      pos_x         <= X_INIT;
      pos_y         <= Y_INIT;
      angle         <= '0;
      cand_x        <= '0;
      cand_y        <= '0;
      map_req_valid <= 1'b0;
      map_cell_x    <= '0;
      map_cell_y    <= '0;
      update_done   <= 1'b0;
      bump          <= 1'b0;
      tick_overrun  <= 1'b0;
    end else begin
      state_q      <= state_d;
      update_done  <= 1'b0;
      bump         <= 1'b0;
      tick_overrun <= frame_tick && (state_q != IDLE);
      if (accept) begin
        if (rot_en) angle <= ang_next;
        if (do_move) begin
          cand_x        <= cand_x_d;
          cand_y        <= cand_y_d;
          map_cell_x    <= cand_x_d[POS_W-1:CELL_SHIFT];
          map_cell_y    <= cand_y_d[POS_W-1:CELL_SHIFT];
          map_req_valid <= 1'b1;
        end else begin
          update_done <= 1'b1;
        end
      end
      if (state_q == REQ && map_req_ready) map_req_valid <= 1'b0;
      if (state_q == WAIT && map_rsp_valid) begin
        update_done <= 1'b1;
        if (map_wall) begin
          bump <= 1'b1;
        end else begin
          pos_x <= cand_x;
          pos_y <= cand_y;
        end
      end
    end
  end
endmodule
